// File: rtl/volume_level.sv
// Volume level meter: tracks the peak microphone amplitude over a window of
// WINDOW accepted samples and turns it into a 0..15 level with instant attack
// and one-step-per-window decay.
module volume_level #(
  parameter int unsigned WINDOW = 4000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_valid,
  input  logic [11:0] mic_in,
  input  logic        freeze,
  output logic [3:0]  level,
  output logic        level_valid
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned AMP_W  = 11;
  localparam int unsigned LVL_W  = 4;
  localparam logic [11:0] MIDPOINT = 12'd2048;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AMP_W-1:0] peak_q, peak_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             level_valid_q, level_valid_d;

  logic [AMP_W-1:0] amp_c;
  logic [AMP_W-1:0] max_amp_c;
  logic [LVL_W-1:0] quant_c;
  logic             closing_c;

  // Rectify around the silence midpoint; samples at or below it carry no amplitude.
  always_comb begin
    amp_c = '0;
    if (mic_in > MIDPOINT) begin
      amp_c = AMP_W'(mic_in - MIDPOINT);
    end
  end

  // Window counting, peak tracking and level update on the closing sample.
  always_comb begin
    cnt_d         = cnt_q;
    peak_d        = peak_q;
    level_d       = level_q;
    level_valid_d = 1'b0;

    // Ties keep the current peak; the closing sample still counts toward it.
    max_amp_c = (amp_c > peak_q) ? amp_c : peak_q;
    quant_c   = max_amp_c[AMP_W-1:AMP_W-LVL_W];
    closing_c = sample_valid && (cnt_q == LAST_CNT);

    if (sample_valid) begin
      if (closing_c) begin
        cnt_d  = '0;
        peak_d = '0;
        if (!freeze) begin
          level_valid_d = 1'b1;
          // Decay branch only runs when quant < level, so level >= 1 and
          // the subtraction cannot wrap below zero.
          if (quant_c >= level_q) begin
            level_d = quant_c;
          end else begin
            level_d = level_q - LVL_W'(1);
          end
        end
      end else begin
        cnt_d  = cnt_q + CNT_W'(1);
        peak_d = max_amp_c;
      end
    end
  end

  // State registers; reset discards any partial window and pending update.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      peak_q        <= '0;
      level_q       <= '0;
      level_valid_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      peak_q        <= peak_d;
      level_q       <= level_d;
      level_valid_q <= level_valid_d;
    end
  end

  assign level       = level_q;
  assign level_valid = level_valid_q;

endmodule

// File: tb/tb_volume_level.sv
// Bench for volume_level: WINDOW=4 instance driven from a vector table and
// hand sequences through an expected-output queue, plus a WINDOW=2 instance
// for back-to-back sample acceptance.
module tb_volume_level;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_valid = 1'b0;
  logic [11:0] mic_in = '0;
  logic        freeze = 1'b0;
  logic [3:0]  level;
  logic        level_valid;

  logic        rst2 = 1'b1;
  logic        sample_valid2 = 1'b0;
  logic [11:0] mic_in2 = '0;
  logic        freeze2 = 1'b0;
  logic [3:0]  level2;
  logic        level_valid2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        r;
    logic        sv;
    logic [11:0] mic;
    logic        frz;
    logic        ev;
    logic [3:0]  el;
  } vec_t;

  vec_t        vecs[$];
  logic [4:0]  exp_q[$];

  volume_level #(.WINDOW(4)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .mic_in(mic_in),
    .freeze(freeze), .level(level), .level_valid(level_valid)
  );

  volume_level #(.WINDOW(2)) dut2 (
    .clk(clk), .rst(rst2), .sample_valid(sample_valid2), .mic_in(mic_in2),
    .freeze(freeze2), .level(level2), .level_valid(level_valid2)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic sv, input int mic, input logic frz,
                     input logic ev, input int el);
    vec_t v;
    v.r = r; v.sv = sv; v.mic = 12'(mic); v.frz = frz; v.ev = ev; v.el = 4'(el);
    vecs.push_back(v);
  endtask

  // Compare the outputs after an edge against the oldest queued expectation.
  task automatic check_out(input string name);
    logic [4:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = exp_q.pop_front();
    if (level_valid !== e[4]) begin
      errors++;
      $display("FAIL %s level_valid: got %b want %b", name, level_valid, e[4]);
    end
    checks++;
    if (level !== e[3:0]) begin
      errors++;
      $display("FAIL %s level: got %0d want %0d", name, level, e[3:0]);
    end
  endtask

  // Drive one cycle of stimulus, queue the expected outputs, check after the edge.
  task automatic step(input string name, input logic r, input logic sv, input int mic,
                      input logic frz, input logic ev, input int el);
    rst = r; sample_valid = sv; mic_in = 12'(mic); freeze = frz;
    exp_q.push_back({ev, 4'(el)});
    @(posedge clk);
    #1;
    check_out(name);
  endtask

  initial begin
    int pulses;

    // Reset state and plain windows.
    add(1, 0, 0,    0, 0, 0);
    add(1, 1, 4095, 0, 0, 0);
    // Four silent samples, one ignored loud sample in between.
    add(0, 1, 2048, 0, 0, 0);
    add(0, 0, 4095, 0, 0, 0);
    add(0, 1, 2048, 0, 0, 0);
    add(0, 1, 2048, 0, 0, 0);
    add(0, 1, 2048, 0, 1, 0);
    add(0, 0, 0,    0, 0, 0);
    // Peak 952 -> level 7, then decay to 6 and 5.
    add(0, 1, 2048, 0, 0, 0);
    add(0, 1, 3000, 0, 0, 0);
    add(0, 1, 2100, 0, 0, 0);
    add(0, 1, 2500, 0, 1, 7);
    for (int i = 0; i < 3; i++) add(0, 1, 2048, 0, 0, 7);
    add(0, 1, 2048, 0, 1, 6);
    for (int i = 0; i < 3; i++) add(0, 1, 2048, 0, 0, 6);
    add(0, 1, 2049, 0, 1, 5);
    // Full-scale closing sample -> 15.
    add(0, 1, 0,    0, 0, 5);
    add(0, 1, 0,    0, 0, 5);
    add(0, 1, 1000, 0, 0, 5);
    add(0, 1, 4095, 0, 1, 15);
    // q=14 below level decays by one; then q equal to level re-pulses at 14.
    add(0, 1, 3840, 0, 0, 15);
    add(0, 1, 2048, 0, 0, 15);
    add(0, 1, 2048, 0, 0, 15);
    add(0, 1, 2048, 0, 1, 14);
    add(0, 1, 2048, 0, 0, 14);
    add(0, 1, 2048, 0, 0, 14);
    add(0, 1, 3840, 0, 0, 14);
    add(0, 1, 2048, 0, 1, 14);

    foreach (vecs[i]) begin
      step($sformatf("vec%0d", i), vecs[i].r, vecs[i].sv, int'(vecs[i].mic),
           vecs[i].frz, vecs[i].ev, int'(vecs[i].el));
    end

    // Back to 15, then freeze across a close: no pulse, level held.
    step("to15_a", 0, 1, 4095, 0, 0, 14);
    step("to15_b", 0, 1, 2048, 0, 0, 14);
    step("to15_c", 0, 1, 2048, 0, 0, 14);
    step("to15_d", 0, 1, 2048, 0, 1, 15);
    step("frz_a",  0, 1, 2048, 1, 0, 15);
    step("frz_b",  0, 1, 2048, 0, 0, 15);
    step("frz_c",  0, 1, 2048, 1, 0, 15);
    step("frz_close", 0, 1, 2048, 1, 0, 15);
    step("frz_idle",  0, 0, 0,    1, 0, 15);
    // Freeze toggled mid-window but low at close: normal decay to 14.
    step("unfrz_a", 0, 1, 2048, 1, 0, 15);
    step("unfrz_b", 0, 1, 2048, 1, 0, 15);
    step("unfrz_c", 0, 1, 2048, 1, 0, 15);
    step("unfrz_close", 0, 1, 2048, 0, 1, 14);
    // Amp 127 quantises to 0, amp 128 to 1: decay 14 -> 13.
    step("q1_a", 0, 1, 2176, 0, 0, 14);
    step("q1_b", 0, 1, 2175, 0, 0, 14);
    step("q1_c", 0, 1, 2048, 0, 0, 14);
    step("q1_d", 0, 1, 2048, 0, 1, 13);

    // Reset mid-window abandons two loud samples; next window counts from 0.
    step("rstmid_a", 0, 1, 4095, 0, 0, 13);
    step("rstmid_b", 0, 1, 4095, 0, 0, 13);
    step("rstmid_r", 1, 1, 4095, 0, 0, 0);
    step("rstmid_1", 0, 1, 2048, 0, 0, 0);
    step("rstmid_2", 0, 1, 2048, 0, 0, 0);
    step("rstmid_3", 0, 1, 2048, 0, 0, 0);
    step("rstmid_4", 0, 1, 2048, 0, 1, 0);
    // Reset coincident with the closing sample suppresses the update.
    step("rstcl_a", 0, 1, 0,    0, 0, 0);
    step("rstcl_b", 0, 1, 0,    0, 0, 0);
    step("rstcl_c", 0, 1, 0,    0, 0, 0);
    step("rstcl_d", 0, 1, 4095, 0, 1, 15);
    step("rstcl_e", 0, 1, 4095, 0, 0, 15);
    step("rstcl_f", 0, 1, 4095, 0, 0, 15);
    step("rstcl_g", 0, 1, 4095, 0, 0, 15);
    step("rstcl_r", 1, 1, 4095, 0, 0, 0);
    step("rstcl_h", 0, 1, 2048, 0, 0, 0);
    step("rstcl_i", 0, 0, 0,    0, 0, 0);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size());
    end

    // WINDOW=2, ten back-to-back samples: a pulse after every even sample.
    rst2 = 1'b1; sample_valid2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst2 = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      sample_valid2 = 1'b1;
      mic_in2 = (i % 2 == 0) ? 12'd2048 : 12'd3000;
      @(posedge clk);
      #1;
      if (level_valid2 === 1'b1) pulses++;
      checks++;
      if (level_valid2 !== ((i % 2) == 1)) begin
        errors++;
        $display("FAIL w2_pulse%0d: got %b want %b", i, level_valid2, (i % 2) == 1);
      end
      checks++;
      if (level2 !== ((i >= 1) ? 4'd7 : 4'd0)) begin
        errors++;
        $display("FAIL w2_level%0d: got %0d want %0d", i, level2, (i >= 1) ? 7 : 0);
      end
    end
    sample_valid2 = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (level_valid2 !== 1'b0) begin
      errors++;
      $display("FAIL w2_idle: got %b want 0", level_valid2);
    end
    checks++;
    if (pulses != 5) begin
      errors++;
      $display("FAIL w2_count: got %0d want 5", pulses);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
